// File: rtl/miriscv_sw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : miriscv_sw_ctrl
//  Brief    : Memory-mapped board-switch peripheral with sync, optional
//             debounce (SW_DEBOUNCE_EN), sticky change bits and an IRQ handshake.
//  Revision : 1.0 - initial release
// ============================================================================
module miriscv_sw_ctrl #(
    parameter int SW_WIDTH        = 16,
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [SW_WIDTH-1:0] sw_i,
    input  logic                req_i,
    input  logic                we_i,
    input  logic [3:0]          addr_i,
    input  logic [31:0]         wdata_i,
    output logic [31:0]         rdata_o,
    output logic                int_req_o,
    input  logic                int_fin_i
);

    localparam logic [3:0] c_ADDR_VAL = 4'h0;
    localparam logic [3:0] c_ADDR_CHG = 4'h4;
    localparam logic [3:0] c_ADDR_EN  = 4'h8;
    localparam logic [3:0] c_ADDR_RAW = 4'hC;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    logic [SW_WIDTH-1:0] r_s1;
    logic [SW_WIDTH-1:0] r_s2;
    logic [SW_WIDTH-1:0] r_sw_val;
    logic [SW_WIDTH-1:0] r_chg;
    logic                r_irq_en;
    state_t              r_state;

    logic [SW_WIDTH-1:0] w_sw_val_next;
    logic [SW_WIDTH-1:0] w_w1c_mask;
    logic [SW_WIDTH-1:0] w_chg_next;
    logic [31:0]         w_rdata;
    logic                w_wr;
    logic                w_rd;
    logic                w_unused;

    assign w_unused = ^{1'b0, wdata_i, 32'(DEBOUNCE_CYCLES)};

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= sw_i;
            r_s2 <= r_s1;
        end
    end

`ifdef SW_DEBOUNCE_EN
    localparam int c_CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SW_WIDTH-1:0] r_cand;
    logic [c_CNT_W-1:0]  r_cnt;

    // Counter saturates at its terminal value, so a stable input keeps committing.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cand <= '0;
            r_cnt  <= '0;
        end else if (r_s2 != r_cand) begin
            r_cand <= r_s2;
            r_cnt  <= '0;
        end else if (r_cnt != c_CNT_MAX) begin
            r_cnt  <= r_cnt + 1'b1;
        end
    end

    always_comb begin
        w_sw_val_next = r_sw_val;
        if ((r_s2 == r_cand) && (r_cnt == c_CNT_MAX)) begin
            w_sw_val_next = r_cand;
        end
    end
`else
    assign w_sw_val_next = r_s2;
`endif

    assign w_wr       = req_i & we_i;
    assign w_rd       = req_i & ~we_i;
    assign w_w1c_mask = (w_wr && (addr_i == c_ADDR_CHG)) ? wdata_i[SW_WIDTH-1:0] : '0;
    // Newly changed bits are OR-ed in after the clear, so a same-cycle set wins.
    assign w_chg_next = (r_chg & ~w_w1c_mask) | (r_sw_val ^ w_sw_val_next);

    always_comb begin
        w_rdata = '0;
        case (addr_i)
            c_ADDR_VAL: w_rdata = 32'(r_sw_val);
            c_ADDR_CHG: w_rdata = 32'(r_chg);
            c_ADDR_EN:  w_rdata = {31'd0, r_irq_en};
            c_ADDR_RAW: w_rdata = 32'(r_s2);
            default:    w_rdata = '0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_sw_val <= '0;
            r_chg    <= '0;
            r_irq_en <= 1'b0;
            rdata_o  <= '0;
        end else begin
            r_sw_val <= w_sw_val_next;
            r_chg    <= w_chg_next;
            if (w_wr && (addr_i == c_ADDR_EN)) begin
                r_irq_en <= wdata_i[0];
            end
            if (w_rd) begin
                rdata_o <= w_rdata;
            end
        end
    end

    // Once raised, the request is held until the core acknowledges it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_IDLE;
            int_req_o <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_irq_en && (r_chg != '0)) begin
                        r_state   <= ST_REQ;
                        int_req_o <= 1'b1;
                    end
                end
                ST_REQ: begin
                    if (int_fin_i) begin
                        r_state   <= ST_DONE;
                        int_req_o <= 1'b0;
                    end
                end
                ST_DONE: begin
                    r_state   <= ST_IDLE;
                    int_req_o <= 1'b0;
                end
                default: begin
                    r_state   <= ST_IDLE;
                    int_req_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_miriscv_sw_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_miriscv_sw_ctrl
//  Brief    : Randomised self-checking bench for miriscv_sw_ctrl against a
//             behavioural model (honours SW_DEBOUNCE_EN like the design).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_miriscv_sw_ctrl;

    localparam int c_D = 4;
`ifdef SW_DEBOUNCE_EN
    localparam bit c_DB  = 1'b1;
    localparam int c_LAT = c_D + 3;
`else
    localparam bit c_DB  = 1'b0;
    localparam int c_LAT = 3;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] sw = '0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  addr = '0;
    logic [31:0] wdata = '0;
    logic [31:0] rdata;
    logic        int_req;
    logic        fin = 1'b0;

    int total = 0;
    int bad = 0;

    miriscv_sw_ctrl #(.SW_WIDTH(16), .DEBOUNCE_CYCLES(c_D)) dut (
        .clk_i(clk), .rst_i(rst), .sw_i(sw), .req_i(req), .we_i(we),
        .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata),
        .int_req_o(int_req), .int_fin_i(fin)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // Reference model: delay line for the synchroniser, run-length rule for
    // debounce, and a request flag with a two-cycle quiet period after ack.
    logic [15:0] m_p1, m_p2, m_sw, m_chg;
    logic        m_en, m_req;
    int          m_cool;
    logic [31:0] m_rdata;
`ifdef SW_DEBOUNCE_EN
    logic [15:0] m_run[$];
`endif

    always @(posedge clk) begin : model
        logic [15:0] nv;
        logic [15:0] clr;
        bit          stable;
        if (rst) begin
            m_p1 <= '0; m_p2 <= '0; m_sw <= '0; m_chg <= '0;
            m_en <= 1'b0; m_req <= 1'b0; m_cool <= 0; m_rdata <= '0;
`ifdef SW_DEBOUNCE_EN
            m_run.delete();
`endif
        end else begin
            nv = m_sw;
`ifdef SW_DEBOUNCE_EN
            m_run.push_back(m_p2);
            if (m_run.size() > c_D + 1) void'(m_run.pop_front());
            if (m_run.size() == c_D + 1) begin
                stable = 1'b1;
                for (int i = 0; i < m_run.size(); i++)
                    if (m_run[i] != m_p2) stable = 1'b0;
                if (stable) nv = m_p2;
            end
`else
            stable = 1'b1;
            if (stable) nv = m_p2;
`endif
            clr = (req && we && addr == 4'h4) ? wdata[15:0] : 16'h0;
            m_chg <= (m_chg & ~clr) | (m_sw ^ nv);
            m_sw  <= nv;
            if (req && we && addr == 4'h8) m_en <= wdata[0];
            if (req && !we) begin
                case (addr)
                    4'h0:    m_rdata <= {16'h0, m_sw};
                    4'h4:    m_rdata <= {16'h0, m_chg};
                    4'h8:    m_rdata <= {31'h0, m_en};
                    4'hC:    m_rdata <= {16'h0, m_p2};
                    default: m_rdata <= '0;
                endcase
            end
            if (m_req) begin
                if (fin) begin m_req <= 1'b0; m_cool <= 1; end
            end else if (m_cool > 0) begin
                m_cool <= m_cool - 1;
            end else if (m_en && m_chg != 16'h0) begin
                m_req <= 1'b1;
            end
            m_p1 <= sw;
            m_p2 <= m_p1;
        end
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic bus_rd(input logic [3:0] a, output logic [31:0] d);
        req = 1'b1; we = 1'b0; addr = a;
        @(negedge clk);
        req = 1'b0;
        d = rdata;
    endtask

    task automatic bus_wr(input logic [3:0] a, input logic [31:0] d);
        req = 1'b1; we = 1'b1; addr = a; wdata = d;
        @(negedge clk);
        req = 1'b0; we = 1'b0;
    endtask

    task automatic pulse_fin();
        fin = 1'b1;
        @(negedge clk);
        fin = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        int first;
        sw = 16'h1111;
        rst = 1'b1;
        cyc(); cyc();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL reset_int_req: got %b want 0", int_req); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", rdata); end
        rst = 1'b0;
        first = -1;
        for (int k = 0; k < 12; k++) begin
            bus_rd(4'h0, d);
            total++; if (d !== m_rdata) begin bad++; $display("FAIL latency_track[%0d]: got %h want %h", k, d, m_rdata); end
            if (first < 0 && d == 32'h1111) first = k;
        end
        total++; if (first !== c_LAT) begin bad++; $display("FAIL latency_edges: got %0d want %0d", first, c_LAT); end
        bus_rd(4'h4, d);
        total++; if (d !== 32'h1111) begin bad++; $display("FAIL reset_chg: got %h want 00001111", d); end
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL no_irq_when_disabled: got %b want 0", int_req); end
    endtask

    task automatic test_irq();
        logic [31:0] d;
        int n;
        bus_wr(4'h4, 32'hFFFF);
        bus_wr(4'h8, 32'h1);
        cyc();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL irq_idle_clear: got %b want 0", int_req); end
        sw = 16'h1110;
        n = 0;
        while (int_req !== 1'b1 && n < 30) begin cyc(); n++; end
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL irq_raise: got %b want 1 within 30 cycles", int_req); end
        bus_rd(4'h4, d);
        total++; if (d !== 32'h0001) begin bad++; $display("FAIL irq_chg: got %h want 00000001", d); end
        pulse_fin();
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL irq_ack_drop: got %b want 0", int_req); end
        for (int k = 0; k < 3; k++) begin
            cyc();
            total++; if (int_req !== m_req) begin bad++; $display("FAIL irq_rearm[%0d]: got %b want %b", k, int_req, m_req); end
        end
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL irq_rearmed: got %b want 1", int_req); end
        bus_wr(4'h4, 32'h0001);
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL irq_no_retract: got %b want 1", int_req); end
        pulse_fin();
        for (int k = 0; k < 5; k++) begin
            total++; if (int_req !== 1'b0) begin bad++; $display("FAIL irq_stays_low[%0d]: got %b want 0", k, int_req); end
            cyc();
        end
    endtask

    task automatic test_glitch();
        logic [31:0] d;
        logic [31:0] exp_chg;
        bit saw;
        bus_wr(4'h8, 32'h0);
        sw = 16'h1111;
        repeat (12) cyc();
        bus_wr(4'h4, 32'hFFFF);
        sw = 16'h1011;
        cyc(); cyc();
        bus_rd(4'hC, d);
        total++; if (d !== 32'h1011) begin bad++; $display("FAIL raw_during_pulse: got %h want 00001011", d); end
        sw = 16'h1111;
        saw = 1'b0;
        for (int k = 0; k < 10; k++) begin
            bus_rd(4'h0, d);
            total++; if (d !== m_rdata) begin bad++; $display("FAIL glitch_val[%0d]: got %h want %h", k, d, m_rdata); end
            if (d == 32'h1011) saw = 1'b1;
        end
        total++; if (saw !== !c_DB) begin bad++; $display("FAIL glitch_visible: got %b want %b", saw, !c_DB); end
        bus_rd(4'h0, d);
        total++; if (d !== 32'h1111) begin bad++; $display("FAIL glitch_final_val: got %h want 00001111", d); end
        exp_chg = c_DB ? 32'h0 : 32'h0100;
        bus_rd(4'h4, d);
        total++; if (d !== exp_chg) begin bad++; $display("FAIL glitch_chg: got %h want %h", d, exp_chg); end
    endtask

    task automatic test_w1c_race();
        logic [31:0] d;
        bus_wr(4'h4, 32'hFFFF);
        sw = 16'h0111;
        repeat (c_LAT - 1) cyc();
        bus_wr(4'h4, 32'h1000);
        bus_rd(4'h4, d);
        total++; if (d !== 32'h1000) begin bad++; $display("FAIL w1c_race_set_wins: got %h want 00001000", d); end
        bus_wr(4'h4, 32'h1000);
        bus_rd(4'h4, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL w1c_clear: got %h want 0", d); end
    endtask

    task automatic test_unmapped();
        logic [31:0] d;
        logic [3:0]  bad_addr[3] = '{4'h1, 4'h6, 4'hF};
        for (int k = 0; k < 3; k++) begin
            bus_rd(4'h0, d);
            bus_rd(bad_addr[k], d);
            total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_rd[%h]: got %h want 0", bad_addr[k], d); end
        end
        bus_wr(4'h0, 32'hFFFF);
        bus_rd(4'h0, d);
        total++; if (d !== 32'h0111) begin bad++; $display("FAIL ro_val_write: got %h want 00000111", d); end
        bus_wr(4'hC, 32'h0);
        bus_rd(4'hC, d);
        total++; if (d !== 32'h0111) begin bad++; $display("FAIL ro_raw_write: got %h want 00000111", d); end
        bus_wr(4'h9, 32'h1);
        bus_rd(4'h8, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL unmapped_wr_en: got %h want 0", d); end
        bus_wr(4'h8, 32'hFFFF_FFFF);
        bus_rd(4'h8, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL irq_en_upper: got %h want 1", d); end
        bus_wr(4'h8, 32'h0);
    endtask

    task automatic test_random();
        bit was_rd;
        for (int k = 0; k < 600; k++) begin
            if ($urandom_range(5) == 0) sw = sw ^ (16'h1 << $urandom_range(15));
            fin = ($urandom_range(7) == 0);
            was_rd = 1'b0;
            case ($urandom_range(5))
                0: begin req = 1'b1; we = 1'b0; addr = 4'($urandom_range(15)); was_rd = 1'b1; end
                1: begin req = 1'b1; we = 1'b0; addr = 4'($urandom_range(3) * 4); was_rd = 1'b1; end
                2: begin req = 1'b1; we = 1'b1; addr = 4'h4; wdata = $urandom; end
                3: begin req = 1'b1; we = 1'b1; addr = 4'h8; wdata = 32'($urandom_range(3)); end
                default: begin req = 1'b0; we = 1'b0; end
            endcase
            @(negedge clk);
            req = 1'b0; we = 1'b0; fin = 1'b0;
            total++; if (int_req !== m_req) begin bad++; $display("FAIL rand_irq[%0d]: got %b want %b", k, int_req, m_req); end
            if (was_rd) begin
                total++; if (rdata !== m_rdata) begin bad++; $display("FAIL rand_rdata[%0d]: got %h want %h", k, rdata, m_rdata); end
            end
        end
    endtask

    task automatic test_reset_in_req();
        logic [31:0] d;
        int n;
        bus_wr(4'h8, 32'h1);
        sw = sw ^ 16'h0001;
        n = 0;
        while (int_req !== 1'b1 && n < 30) begin cyc(); n++; end
        total++; if (int_req !== 1'b1) begin bad++; $display("FAIL rst_req_setup: got %b want 1", int_req); end
        bus_rd(4'hC, d);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        total++; if (int_req !== 1'b0) begin bad++; $display("FAIL rst_in_req_irq: got %b want 0", int_req); end
        total++; if (rdata !== 32'h0) begin bad++; $display("FAIL rst_in_req_rdata: got %h want 0", rdata); end
        bus_rd(4'hC, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_raw: got %h want 0", d); end
        bus_rd(4'h0, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_val: got %h want 0", d); end
        bus_rd(4'h4, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_chg: got %h want 0", d); end
        bus_rd(4'h8, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL rst_en: got %h want 0", d); end
    endtask

    initial begin
        cyc(); cyc();
        test_reset();
        test_irq();
        test_glitch();
        test_w1c_race();
        test_unmapped();
        test_random();
        test_reset_in_req();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
